mul: RTL

MUL -- requirements
Module: mul

---
 rtl/mul.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mul.sv
// mul: iterative 32x32 -> 64-bit multiplier, signed or unsigned per request.
// Default build: radix-2 shift-add on operand magnitudes, 32 BUSY cycles.
// Define MUL_RADIX4_EN for radix-4 Booth on 34-bit extended operands, 17 BUSY cycles.
module mul (
   input  logic        clk,
   input  logic        reset,
   input  logic        mul_en,
   input  logic        mul_signed,
   input  logic [31:0] x,
   input  logic [31:0] y,
   input  logic        mul_cancel,
   output logic        mul_ready,
   output logic [63:0] p,
   output logic        complete
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

`ifdef MUL_RADIX4_EN
   localparam int         STEP = 2;       // multiplier bits consumed per cycle
   localparam int         RW   = 35;      // {y extended to 34 bits, implicit y[-1]=0}
   localparam logic [5:0] LAST = 6'd16;   // index of the final iteration
`else
   localparam int         STEP = 1;
   localparam int         RW   = 33;      // |y| can be 2^31, so 33 bits
   localparam logic [5:0] LAST = 6'd31;
`endif

   state_t        r_state;
   logic          r_ready;
   logic          r_complete;
   logic [63:0]   r_p;
   logic [63:0]   r_acc;
   logic [63:0]   r_mcand;
   logic [RW-1:0] r_mplier;
   logic [5:0]    r_cnt;
`ifndef MUL_RADIX4_EN
   logic          r_neg;
`endif

   logic          w_accept;
   logic          w_sx;
   logic          w_sy;
   logic [63:0]   w_mcand_init;
   logic [RW-1:0] w_mplier_init;
   logic [63:0]   w_addend;
   logic [63:0]   w_sum;
   logic [63:0]   w_result;
`ifndef MUL_RADIX4_EN
   logic [32:0]   w_xm;
   logic [32:0]   w_ym;
`endif

   // A cancel in IDLE/DONE blocks a simultaneous start.
   assign w_accept = mul_en & r_ready & ~mul_cancel;
   assign w_sx     = mul_signed & x[31];
   assign w_sy     = mul_signed & y[31];

`ifdef MUL_RADIX4_EN
   // Only the low 64 bits of the Booth sum are kept; they are exact modulo 2^64,
   // so the multiplicand is sign-extended straight to 64 bits.
   assign w_mcand_init  = {{32{w_sx}}, x};
   assign w_mplier_init = {{2{w_sy}}, y, 1'b0};
   assign w_result      = w_sum;
`else
   // 33-bit magnitudes so that 0x80000000 (signed) becomes +2^31.
   assign w_xm          = w_sx ? (33'd0 - {1'b1, x}) : {1'b0, x};
   assign w_ym          = w_sy ? (33'd0 - {1'b1, y}) : {1'b0, y};
   assign w_mcand_init  = {31'd0, w_xm};
   assign w_mplier_init = w_ym;
   assign w_result      = r_neg ? (64'd0 - w_sum) : w_sum;
`endif

   // Partial product selected by the current multiplier digit.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_addend unassigned (no latch).
      w_addend = '0;
`ifdef MUL_RADIX4_EN
      case (r_mplier[2:0])
         3'b001, 3'b010: w_addend = r_mcand;
         3'b011:         w_addend = r_mcand << 1;
         3'b100:         w_addend = 64'd0 - (r_mcand << 1);
         3'b101, 3'b110: w_addend = 64'd0 - r_mcand;
         default:        w_addend = '0;
      endcase
`else
      if (r_mplier[0]) w_addend = r_mcand;
`endif
      w_sum = r_acc + w_addend;
   end

   // Control FSM plus iterative datapath; all outputs are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the datapath registers are a handful of flops, not a memory array,
         // so resetting them is cheap and keeps every state deterministic.
         r_state    <= S_IDLE;
         r_ready    <= 1'b1;
         r_complete <= 1'b0;
         r_p        <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_cnt      <= '0;
`ifndef MUL_RADIX4_EN
         r_neg      <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         r_complete <= 1'b0;
         case (r_state)
            S_BUSY: begin
               if (mul_cancel) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_acc    <= w_sum;
                  r_mcand  <= r_mcand << STEP;
                  r_mplier <= r_mplier >> STEP;
                  r_cnt    <= r_cnt + 6'd1;
                  if (r_cnt == LAST) begin
                     r_p        <= w_result;
                     r_complete <= 1'b1;
                     r_state    <= S_DONE;
                     r_ready    <= 1'b1;
                  end
               end
            end
            default: begin
               // IDLE and DONE behave alike: accept a start or settle in IDLE.
               if (w_accept) begin
                  r_state  <= S_BUSY;
                  r_ready  <= 1'b0;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_mcand  <= w_mcand_init;
                  r_mplier <= w_mplier_init;
`ifndef MUL_RADIX4_EN
                  r_neg    <= mul_signed & (x[31] ^ y[31]);
`endif
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
         endcase
      end
   end

   assign mul_ready = r_ready;
   assign p         = r_p;
   assign complete  = r_complete;

endmodule
